// File: rtl/ram_arb_pkg.sv
//----------------------------------------------------------------------------
// Module : ram_arb_pkg
// Brief  : Shared types and helpers for the byte-RAM word arbiter.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 2;

  function automatic logic [7:0] word_byte(input logic [8*WORD_BYTES-1:0] w,
                                           input logic [CNT_W-1:0]        k);
    return w[8*k +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
//----------------------------------------------------------------------------
// Module : rr_arbiter2
// Brief  : Two-way round-robin arbiter; history advances only when enabled.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output port_t      o_grant
);

  port_t r_last;
  logic  w_any;

  assign w_any = |i_req;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    o_grant = PORT_I;
    if (i_req[0] && i_req[1])
      o_grant = (r_last == PORT_D) ? PORT_I : PORT_D;
    else if (i_req[1])
      o_grant = PORT_D;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_last <= PORT_D;
    else if (i_en && w_any)
      r_last <= o_grant;
  end

endmodule

`default_nettype wire

// File: rtl/ram_word_arbiter.sv
//----------------------------------------------------------------------------
// Module : ram_word_arbiter
// Brief  : Shares a 512x8 registered-read RAM between fetch and load/store
//          ports, sequencing each 32-bit little-endian word as 4 byte cycles.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module ram_word_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RAM_AW = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [RAM_AW-1:0]       i_addr,
  output logic [8*WORD_BYTES-1:0] i_rdata,
  output logic                    i_ack,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [RAM_AW-1:0]       d_addr,
  input  logic [8*WORD_BYTES-1:0] d_wdata,
  input  logic [WORD_BYTES-1:0]   d_be,
  output logic [8*WORD_BYTES-1:0] d_rdata,
  output logic                    d_ack,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [7:0]              ram_din,
  output logic                    ram_we,
  input  logic [7:0]              ram_dout
);

  localparam logic [CNT_W-1:0]  c_last_cnt  = CNT_W'(WORD_BYTES - 1);
  localparam logic [RAM_AW-1:0] c_align_msk = ~RAM_AW'(WORD_BYTES - 1);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  port_t                     r_port;
  logic [RAM_AW-1:0]         r_base;
  logic                      r_we;
  logic [8*WORD_BYTES-1:0]   r_wdata;
  logic [WORD_BYTES-1:0]     r_be;
  logic [8*WORD_BYTES-1:0]   r_rdata;

  port_t                     w_grant;
  logic [RAM_AW-1:0]         w_base;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [CNT_W-1:0]          w_cap;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_state == IDLE),
    .i_req   ({d_req, i_req}),
    .o_grant (w_grant)
  );

  assign w_base    = ((w_grant == PORT_D) ? d_addr : i_addr) & c_align_msk;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_cap     = r_cnt - 1'b1;

  assign i_rdata = r_rdata;
  assign d_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_port   <= PORT_D;
      r_base   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_rdata  <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req || d_req) begin
            r_port   <= w_grant;
            r_base   <= w_base;
            r_we     <= (w_grant == PORT_D) && d_we;
            r_wdata  <= d_wdata;
            r_be     <= d_be;
            r_cnt    <= '0;
            ram_addr <= w_base;
            ram_din  <= d_wdata[7:0];
            ram_we   <= (w_grant == PORT_D) && d_we && d_be[0];
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          // RAM read data lags the address by one cycle.
          if (r_cnt != '0)
            r_rdata[8*w_cap +: 8] <= ram_dout;
          if (r_cnt == c_last_cnt) begin
            ram_we  <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_cnt    <= w_cnt_nxt;
            ram_addr <= r_base + RAM_AW'(w_cnt_nxt);
            ram_din  <= word_byte(r_wdata, w_cnt_nxt);
            ram_we   <= r_we && r_be[w_cnt_nxt];
          end
        end
        DRAIN: begin
          r_rdata[8*c_last_cnt +: 8] <= ram_dout;
          if (r_port == PORT_D)
            d_ack <= 1'b1;
          else
            i_ack <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_word_arbiter.sv
//----------------------------------------------------------------------------
// Module : tb_ram_word_arbiter
// Brief  : Directed and randomized bench for ram_word_arbiter with a byte RAM.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_ram_word_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [8:0]  i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  logic [7:0]  ram_mem [512];
  logic [7:0]  ref_mem [512];
  bit          model_last_d;
  int          n_checks;
  int          n_errors;

  ram_word_arbiter #(.RAM_AW(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM with registered read.
  always @(posedge clk) begin
    if (ram_we)
      ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [8:0] a);
    logic [8:0] b;
    b = {a[8:2], 2'b00};
    return {ref_mem[b + 9'd3], ref_mem[b + 9'd2], ref_mem[b + 9'd1], ref_mem[b]};
  endfunction

  function automatic void ref_store(input logic [8:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [8:0] b;
    b = {a[8:2], 2'b00};
    for (int k = 0; k < 4; k++)
      if (be[k]) ref_mem[b + 9'(k)] = wd[8*k +: 8];
  endfunction

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_last_d = 1'b1;
  endtask

  // Raise one or both requests in IDLE, check every bus cycle, wait for the acks.
  task automatic run_txn(input bit ir, input bit dr, input logic [8:0] ia, input bit we,
                         input logic [8:0] da, input logic [31:0] wd, input logic [3:0] be);
    bit         first_d, two, i_done, d_done, pd;
    int         c, k;
    logic [8:0] base;
    logic       exp_we;
    two          = ir && dr;
    first_d      = two ? !model_last_d : dr;
    model_last_d = two ? !first_d : first_d;
    i_done = !ir; d_done = !dr;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_be = be;
    c = 0;
    while (!(i_done && d_done) && c < 30) begin
      @(posedge clk); @(negedge clk);
      c++;
      k = -1; pd = first_d;
      if (c >= 1 && c <= 4) k = c - 1;
      else if (two && c >= 8 && c <= 11) begin k = c - 8; pd = !first_d; end
      if (k < 0) begin
        check("we_outside_access", ram_we, 0);
      end else begin
        base   = pd ? {da[8:2], 2'b00} : {ia[8:2], 2'b00};
        exp_we = pd && we && be[k];
        check("ram_addr", ram_addr, base + 9'(k));
        check("ram_we", ram_we, exp_we);
        if (exp_we) check("ram_din", ram_din, wd[8*k +: 8]);
      end
      // Granted inputs must be latched: disturb them, then drop the request.
      if (c == 2) begin
        if (first_d) begin
          d_addr = 9'($urandom); d_wdata = $urandom; d_be = 4'($urandom); d_we = 1'($urandom);
        end else begin
          i_addr = 9'($urandom);
        end
      end
      if (c == 3) begin
        if (first_d) d_req = 1'b0; else i_req = 1'b0;
      end
      check("ack_exclusive", i_ack & d_ack, 0);
      if (i_ack) begin
        if (i_done) check("i_ack_spurious", i_ack, 0);
        else begin
          check("i_ack_cycle", c, first_d ? 13 : 6);
          check("i_rdata", i_rdata, ref_word(ia));
          i_done = 1'b1; i_req = 1'b0;
        end
      end
      if (d_ack) begin
        if (d_done) check("d_ack_spurious", d_ack, 0);
        else begin
          check("d_ack_cycle", c, first_d ? 6 : 13);
          if (we) ref_store(da, wd, be);
          else    check("d_rdata", d_rdata, ref_word(da));
          d_done = 1'b1; d_req = 1'b0;
        end
      end
    end
    if (!(i_done && d_done)) check("ack_timeout", 32'(c), 0);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ack_one_cycle", i_ack | d_ack, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    for (int a = 0; a < 512; a++) begin ram_mem[a] = 8'h00; ref_mem[a] = 8'h00; end
    i_addr = '0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_rdata", d_rdata, 0);
    rst = 1'b0;
    model_last_d = 1'b1;

    // Full store, misaligned fetch, partial store, load back.
    run_txn(0, 1, 9'h000, 1, 9'h010, 32'hDEADBEEF, 4'b1111);
    run_txn(1, 0, 9'h013, 0, 9'h000, 32'h0, 4'b0000);
    check("fetch_word", ref_word(9'h013), 32'hDEADBEEF);
    run_txn(0, 1, 9'h000, 1, 9'h010, 32'h11223344, 4'b0101);
    run_txn(0, 1, 9'h000, 0, 9'h010, 32'h0, 4'b0000);
    check("partial_word", ref_word(9'h010), 32'hDE22BE44);

    // Simultaneous requests right after reset alternate I, D, I, D.
    do_reset();
    run_txn(1, 1, 9'h010, 0, 9'h014, 32'h0, 4'b0000);
    run_txn(1, 1, 9'h018, 0, 9'h010, 32'h0, 4'b0000);

    // Reset taking effect at the start of ACCESS byte 2 leaves bytes 0-1 written.
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 9'h020; d_wdata = 32'hAABBCCDD; d_be = 4'hF;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_ram_we", ram_we, 0);
    check("midrst_d_ack", d_ack, 0);
    rst = 1'b0;
    model_last_d = 1'b1;
    ref_store(9'h020, 32'hAABBCCDD, 4'b0011);
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); @(negedge clk);
      check("midrst_no_ack", i_ack | d_ack, 0);
      check("midrst_we_idle", ram_we, 0);
    end
    run_txn(0, 1, 9'h000, 0, 9'h020, 32'h0, 4'b0000);
    check("midrst_word", ref_word(9'h020), 32'h0000CCDD);

    // Top of memory, no wrap.
    run_txn(0, 1, 9'h000, 1, 9'h1FF, 32'hCAFEF00D, 4'b1111);
    run_txn(1, 0, 9'h1FF, 0, 9'h000, 32'h0, 4'b0000);
    check("no_wrap_low", ref_word(9'h000), 32'h0);

    // Randomized mix of fetches, loads, stores and ties.
    for (int t = 0; t < 60; t++) begin
      int unsigned pat;
      pat = $urandom_range(1, 3);
      run_txn(pat[0], pat[1], 9'($urandom), 1'($urandom), 9'($urandom), $urandom, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
